rcv_cu: RTL and testbench

Receive-side control and assembly unit for the serial link. It collects bytes from the UART receiver, LSB first then MSB, and assembles each pair into a 16-bit sample. It presents that sample to the FIR input over a valid/ready handshake. It is the counterpart of the transmit control unit, which serialises FIR results as LSB then MSB. It also detects inter-byte timeouts and overruns.

---
 rtl/rcv_pkg.sv | 14 +
 rtl/rcv_timeout_cnt.sv | 37 +++
 rtl/rcv_cu.sv | 123 ++++++++++++
 tb/tb_rcv_cu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// Shared types and widths for the receive-side
// control unit and its timeout counter.
package rcv_pkg;

  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    WAIT_LSB = 2'b00,
    WAIT_MSB = 2'b01,
    HOLD     = 2'b10
  } state_t;

endpackage

// File: rtl/rcv_timeout_cnt.sv
// Inter-byte timeout counter with a registered
// terminal-count flag; shared with the tx watchdog.
module rcv_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = clr ? '0
                   : r_cnt + CNT_W'(1);

  // expired mirrors (count == TERM) so the FSM sees no adder path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (clr || en) begin
      r_cnt     <= w_cnt_nxt;
      r_expired <= (w_cnt_nxt == TERM);
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/rcv_cu.sv
// Receive control unit: pairs UART bytes LSB/MSB into
// 16-bit samples for the FIR, flags timeout/overrun.
module rcv_cu
  import rcv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RxD_data_ready,
  input  logic [BYTE_W-1:0]   RxD_data,
  input  logic                FIR_ready,
  input  logic                clr_err,
  output logic [SAMPLE_W-1:0] FIR_in,
  output logic                FIR_valid,
  output logic                overrun,
  output logic                frame_err
);

  state_t r_state;
  state_t w_next;

  logic [BYTE_W-1:0]   r_lsb;
  logic [SAMPLE_W-1:0] r_fir_in;
  logic                r_valid;
  logic                r_overrun;
  logic                r_frame_err;

  logic w_cap_lsb;
  logic w_load;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_ovr_set;
  logic w_ferr_set;
  logic w_expired;

  rcv_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_cnt_clr),
    .en      (w_cnt_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= WAIT_LSB;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cap_lsb  = 1'b0;
    w_load     = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_en   = 1'b0;
    w_ovr_set  = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_state)
      WAIT_LSB: begin
        if (RxD_data_ready) begin
          w_cap_lsb = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = WAIT_MSB;
        end
      end
      WAIT_MSB: begin
        // a byte on the terminal cycle still wins
        if (RxD_data_ready) begin
          w_load = 1'b1;
          w_next = HOLD;
        end else if (w_expired) begin
          w_ferr_set = 1'b1;
          w_next     = WAIT_LSB;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (FIR_ready) begin
          if (RxD_data_ready) begin
            w_cap_lsb = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = WAIT_MSB;
          end else begin
            w_next = WAIT_LSB;
          end
        end else if (RxD_data_ready) begin
          w_ovr_set = 1'b1;
        end
      end
      default: w_next = WAIT_LSB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lsb       <= '0;
      r_fir_in    <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid <= (w_next == HOLD);
      if (w_cap_lsb)       r_lsb <= RxD_data;
      else if (w_ferr_set) r_lsb <= '0;
      if (w_load) r_fir_in <= {RxD_data, r_lsb};
      r_overrun   <= w_ovr_set
                   | (r_overrun & ~clr_err);
      r_frame_err <= w_ferr_set
                   | (r_frame_err & ~clr_err);
    end
  end

  assign FIR_in    = r_fir_in;
  assign FIR_valid = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_rcv_cu.sv
// Bench for rcv_cu: directed vector table, hand
// sequences for reset/backpressure, random vs model.
module tb_rcv_cu;

  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic        strobe;
  logic [7:0]  data;
  logic        ready;
  logic        clr;
  logic [15:0] fir_in;
  logic        fir_valid;
  logic        ovr;
  logic        ferr;

  int checks;
  int errors;

  rcv_cu #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD_data_ready (strobe),
    .RxD_data       (data),
    .FIR_ready      (ready),
    .clr_err        (clr),
    .FIR_in         (fir_in),
    .FIR_valid      (fir_valid),
    .overrun        (ovr),
    .frame_err      (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  d;
    logic        r;
    logic        c;
    logic        ev;
    logic [15:0] ef;
    logic        eo;
    logic        ee;
  } vec_t;

  vec_t tv[$];

  // model state: pending LSB, held sample, flags
  bit          m_held;
  bit          m_have;
  logic [7:0]  m_lsb;
  logic [15:0] m_fir;
  int          m_age;
  bit          m_ovr;
  bit          m_ferr;

  function automatic logic [18:0] outs();
    return {fir_valid, fir_in, ovr, ferr};
  endfunction

  task automatic chk(input string nm,
                     input logic [18:0] act,
                     input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  task automatic add(input logic s,
                     input logic [7:0] d,
                     input logic r, input logic c,
                     input logic ev,
                     input logic [15:0] ef,
                     input logic eo, input logic ee);
    vec_t v;
    v.s = s; v.d = d; v.r = r; v.c = c;
    v.ev = ev; v.ef = ef; v.eo = eo; v.ee = ee;
    tv.push_back(v);
  endtask

  task automatic step(input logic s,
                      input logic [7:0] d,
                      input logic r, input logic c);
    strobe = s; data = d; ready = r; clr = c;
    @(posedge clk);
    #1;
    strobe = 1'b0; ready = 1'b0; clr = 1'b0;
  endtask

  task automatic model_reset();
    m_held = 0; m_have = 0; m_lsb = '0;
    m_fir = '0; m_age = 0;
    m_ovr = 0; m_ferr = 0;
  endtask

  task automatic model_step(input logic s,
                            input logic [7:0] d,
                            input logic r,
                            input logic c);
    bit os;
    bit fs;
    os = 0;
    fs = 0;
    if (m_held) begin
      if (r) begin
        m_held = 0;
        if (s) begin
          m_have = 1; m_lsb = d; m_age = 0;
        end
      end else if (s) begin
        os = 1;
      end
    end else if (m_have) begin
      if (s) begin
        m_held = 1; m_fir = {d, m_lsb};
        m_have = 0;
      end else if (m_age == T - 1) begin
        fs = 1; m_have = 0;
      end else begin
        m_age++;
      end
    end else if (s) begin
      m_have = 1; m_lsb = d; m_age = 0;
    end
    m_ovr  = os | (m_ovr & !c);
    m_ferr = fs | (m_ferr & !c);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    strobe = 0; data = '0; ready = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    strobe = 0; data = '0; ready = 0; clr = 0;
    #2;
    chk("reset", outs(), 19'h0);
    do_reset();

    add(1, 8'h34, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 8'h12, 0, 0, 1, 16'h1234, 0, 0);
    add(0, 8'h00, 1, 0, 0, 16'h1234, 0, 0);
    add(1, 8'hEF, 0, 0, 0, 16'h1234, 0, 0);
    add(1, 8'hBE, 0, 0, 1, 16'hBEEF, 0, 0);
    add(1, 8'hAA, 0, 0, 1, 16'hBEEF, 1, 0);
    add(0, 8'h00, 0, 1, 1, 16'hBEEF, 0, 0);
    add(1, 8'h55, 1, 0, 0, 16'hBEEF, 0, 0);
    add(1, 8'h66, 0, 0, 1, 16'h6655, 0, 0);
    add(0, 8'h00, 1, 0, 0, 16'h6655, 0, 0);
    add(1, 8'h01, 0, 0, 0, 16'h6655, 0, 0);
    add(1, 8'h02, 0, 0, 1, 16'h0201, 0, 0);
    add(1, 8'hAA, 0, 1, 1, 16'h0201, 1, 0);
    add(0, 8'h00, 0, 1, 1, 16'h0201, 0, 0);
    add(0, 8'h00, 1, 0, 0, 16'h0201, 0, 0);
    add(1, 8'h01, 0, 0, 0, 16'h0201, 0, 0);
    for (int i = 0; i < T - 1; i++)
      add(0, 8'h00, 0, 0, 0, 16'h0201, 0, 0);
    add(0, 8'h00, 0, 0, 0, 16'h0201, 0, 1);
    add(1, 8'h02, 0, 0, 0, 16'h0201, 0, 1);
    add(1, 8'h03, 0, 0, 1, 16'h0302, 0, 1);
    add(0, 8'h00, 1, 1, 0, 16'h0302, 0, 0);
    add(1, 8'h11, 0, 0, 0, 16'h0302, 0, 0);
    for (int i = 0; i < T - 1; i++)
      add(0, 8'h00, 0, 0, 0, 16'h0302, 0, 0);
    add(1, 8'h22, 0, 0, 1, 16'h2211, 0, 0);
    add(0, 8'h00, 1, 0, 0, 16'h2211, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].s, tv[i].d, tv[i].r, tv[i].c);
      chk($sformatf("vec%0d", i), outs(),
          {tv[i].ev, tv[i].ef,
           tv[i].eo, tv[i].ee});
    end

    // async reset mid-WAIT_MSB, partial byte lost
    step(1, 8'h34, 0, 0);
    step(1, 8'h12, 0, 0);
    step(1, 8'hAA, 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h77, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async", outs(), 19'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 8'h34, 0, 0);
    chk("rst_lsb", outs(), 19'h0);
    step(1, 8'h12, 0, 0);
    chk("rst_msb", outs(), {1'b1, 16'h1234, 2'b00});
    step(0, 8'h00, 1, 0);
    chk("rst_hs", outs(), {1'b0, 16'h1234, 2'b00});

    step(1, 8'hEF, 0, 0);
    step(1, 8'hBE, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h00, 0, 0);
      chk("bp_hold", outs(),
          {1'b1, 16'hBEEF, 2'b00});
    end
    step(0, 8'h00, 1, 0);
    chk("bp_drop", outs(), {1'b0, 16'hBEEF, 2'b00});

    do_reset();
    model_reset();
    begin
      int dens;
      logic s, r, c;
      logic [7:0] d;
      dens = 30;
      for (int n = 0; n < 3000; n++) begin
        if (n % 100 == 0) begin
          case ($urandom_range(0, 2))
            0: dens = 5;
            1: dens = 30;
            default: dens = 90;
          endcase
        end
        s = ($urandom_range(0, 99) < dens);
        d = 8'($urandom);
        r = 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 19) == 0);
        model_step(s, d, r, c);
        step(s, d, r, c);
        chk($sformatf("rand%0d", n), outs(),
            {m_held, m_fir, m_ovr, m_ferr});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
